// File: rtl/fft_sample_framer.sv
// Ping-pong framer feeding the 8-point fp16 FFT core: packs N serial samples per frame, start/done issue.
// Define FFT_FRAMER_BITREV_EN to store samples in bit-reversed slot order for in-place DIT cores.
module fft_sample_framer #(
    parameter int N     = 8,
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [N*WIDTH-1:0]   frame,
    output logic                 start,
    input  logic                 done,
    output logic [15:0]          frames_issued,
    output logic                 overflow_seen
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} fsm_t;

    logic [1:0][N-1:0][WIDTH-1:0] bank_q, bank_d;
    bank_state_t                  bank_state_q [2];
    bank_state_t                  bank_state_d [2];
    logic                         wr_bank_q, wr_bank_d;
    logic                         rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]             wr_idx_q, wr_idx_d;
    fsm_t                         fsm_q, fsm_d;
    logic [N*WIDTH-1:0]           frame_q, frame_d;
    logic                         start_q, start_d;
    logic [15:0]                  frames_q, frames_d;
    logic                         overflow_q, overflow_d;
    logic                         accept;
    logic [IDX_W-1:0]             wr_elem;

    function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] s;
`ifdef FFT_FRAMER_BITREV_EN
        for (int i = 0; i < IDX_W; i++) begin
            s[i] = idx[IDX_W-1-i];
        end
`else
        s = idx;
`endif
        return s;
    endfunction

    assign in_ready = (bank_state_q[wr_bank_q] != BANK_FULL);
    assign accept   = in_valid && in_ready && !flush;
    // Slot 0 lives in the MSBs; with N a power of two, element N-1-slot is just ~slot.
    assign wr_elem  = ~slot_of(wr_idx_q);

    always_comb begin
        bank_d          = bank_q;
        bank_state_d[0] = bank_state_q[0];
        bank_state_d[1] = bank_state_q[1];
        wr_bank_d       = wr_bank_q;
        rd_bank_d       = rd_bank_q;
        wr_idx_d        = wr_idx_q;
        fsm_d           = fsm_q;
        frame_d         = frame_q;
        start_d         = start_q;
        frames_d        = frames_q;
        overflow_d      = overflow_q;

        case (fsm_q)
            ST_IDLE: begin
                if (bank_state_q[rd_bank_q] == BANK_FULL) begin
                    frame_d = bank_q[rd_bank_q];
                    start_d = 1'b1;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (done) begin
                    start_d                 = 1'b0;
                    bank_state_d[rd_bank_q] = BANK_EMPTY;
                    rd_bank_d               = ~rd_bank_q;
                    frames_d                = frames_q + 16'd1;
                    fsm_d                   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!done) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase

        // A release only ever targets a FULL bank, so it cannot collide with the write side below.
        if (flush) begin
            if (bank_state_q[wr_bank_q] == BANK_FILLING) begin
                bank_state_d[wr_bank_q] = BANK_EMPTY;
                wr_idx_d                = '0;
            end
        end else if (accept) begin
            bank_d[wr_bank_q][wr_elem] = in_data;
            if (wr_idx_q == IDX_W'(N-1)) begin
                bank_state_d[wr_bank_q] = BANK_FULL;
                wr_idx_d                = '0;
                wr_bank_d               = ~wr_bank_q;
            end else begin
                bank_state_d[wr_bank_q] = BANK_FILLING;
                wr_idx_d                = wr_idx_q + IDX_W'(1);
            end
        end

        if (in_valid && !in_ready) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q          <= '0;
            bank_state_q[0] <= BANK_EMPTY;
            bank_state_q[1] <= BANK_EMPTY;
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            wr_idx_q        <= '0;
            fsm_q           <= ST_IDLE;
            frame_q         <= '0;
            start_q         <= 1'b0;
            frames_q        <= '0;
            overflow_q      <= 1'b0;
        end else begin
            bank_q          <= bank_d;
            bank_state_q[0] <= bank_state_d[0];
            bank_state_q[1] <= bank_state_d[1];
            wr_bank_q       <= wr_bank_d;
            rd_bank_q       <= rd_bank_d;
            wr_idx_q        <= wr_idx_d;
            fsm_q           <= fsm_d;
            frame_q         <= frame_d;
            start_q         <= start_d;
            frames_q        <= frames_d;
            overflow_q      <= overflow_d;
        end
    end

    assign frame         = frame_q;
    assign start         = start_q;
    assign frames_issued = frames_q;
    assign overflow_seen = overflow_q;

endmodule

// File: tb/tb_fft_sample_framer.sv
// Directed self-checking bench for fft_sample_framer; inputs change and outputs are sampled on the falling edge.
module tb_fft_sample_framer;

    logic         clk;
    logic         reset;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [255:0] frame;
    logic         start;
    logic         done;
    logic [15:0]  frames_issued;
    logic         overflow_seen;

    int n_compared;
    int n_failed;
    logic [31:0] exp_samples [8];

    fft_sample_framer #(.N(8), .WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .frame         (frame),
        .start         (start),
        .done          (done),
        .frames_issued (frames_issued),
        .overflow_seen (overflow_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] pack_exp();
        logic [255:0] f;
        int slot;
        f = '0;
        for (int k = 0; k < 8; k++) begin
`ifdef FFT_FRAMER_BITREV_EN
            slot = (k % 2) * 4 + ((k / 2) % 2) * 2 + (k / 4);
`else
            slot = k;
`endif
            f[(8 - slot) * 32 - 1 -: 32] = exp_samples[k];
        end
        return f;
    endfunction

    task automatic send_sample(input logic [31:0] d);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            n_compared++; n_failed++;
            $display("[TB] FAIL send_ready_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_compared++; if (start !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_start: got %b required 0", start); end
        n_compared++; if (frame !== 256'h0) begin n_failed++; $display("[TB] FAIL reset_frame: got %h required 0", frame); end
        n_compared++; if (frames_issued !== 16'd0) begin n_failed++; $display("[TB] FAIL reset_count: got %0d required 0", frames_issued); end
        n_compared++; if (overflow_seen !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_overflow: got %b required 0", overflow_seen); end
        n_compared++; if (in_ready !== 1'b1) begin n_failed++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_single_frame();
        logic [15:0] vals [8];
        logic [255:0] exp_frame;
        vals = '{16'h3c00, 16'h4000, 16'h4200, 16'h4400, 16'h4400, 16'h4200, 16'h4000, 16'h3c00};
        for (int k = 0; k < 8; k++) exp_samples[k] = {vals[k], 16'h0000};
`ifdef FFT_FRAMER_BITREV_EN
        exp_frame = pack_exp();
`else
        exp_frame = 256'h3c000000_40000000_42000000_44000000_44000000_42000000_40000000_3c000000;
`endif
        for (int k = 0; k < 8; k++) send_sample(exp_samples[k]);
        n_compared++; if (start !== 1'b0) begin n_failed++; $display("[TB] FAIL single_start_early: got %b required 0", start); end
        @(negedge clk);
        n_compared++; if (start !== 1'b1) begin n_failed++; $display("[TB] FAIL single_start: got %b required 1", start); end
        n_compared++; if (frame !== exp_frame) begin n_failed++; $display("[TB] FAIL single_frame: got %h required %h", frame, exp_frame); end
        n_compared++; if (frames_issued !== 16'd0) begin n_failed++; $display("[TB] FAIL single_count0: got %0d required 0", frames_issued); end
        n_compared++; if (in_ready !== 1'b1) begin n_failed++; $display("[TB] FAIL single_in_ready: got %b required 1", in_ready); end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        n_compared++; if (start !== 1'b0) begin n_failed++; $display("[TB] FAIL done_start_fall: got %b required 0", start); end
        n_compared++; if (frames_issued !== 16'd1) begin n_failed++; $display("[TB] FAIL done_count1: got %0d required 1", frames_issued); end
        repeat (3) @(negedge clk);
        n_compared++; if (start !== 1'b0) begin n_failed++; $display("[TB] FAIL idle_start_low: got %b required 0", start); end
        n_compared++; if (frame !== exp_frame) begin n_failed++; $display("[TB] FAIL idle_frame_hold: got %h required %h", frame, exp_frame); end
    endtask

    task automatic test_back_to_back();
        int accepted;
        accepted = 0;
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA000_0000 | i;
            if (in_ready === 1'b1) accepted++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) exp_samples[k] = 32'hA000_0000 | k;
        n_compared++; if (accepted !== 16) begin n_failed++; $display("[TB] FAIL b2b_accepted: got %0d required 16", accepted); end
        n_compared++; if (in_ready !== 1'b0) begin n_failed++; $display("[TB] FAIL b2b_in_ready_low: got %b required 0", in_ready); end
        n_compared++; if (overflow_seen !== 1'b1) begin n_failed++; $display("[TB] FAIL b2b_overflow: got %b required 1", overflow_seen); end
        n_compared++; if (start !== 1'b1) begin n_failed++; $display("[TB] FAIL b2b_start1: got %b required 1", start); end
        n_compared++; if (frame !== pack_exp()) begin n_failed++; $display("[TB] FAIL b2b_frame1: got %h required %h", frame, pack_exp()); end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        n_compared++; if (in_ready !== 1'b1) begin n_failed++; $display("[TB] FAIL b2b_in_ready_release: got %b required 1", in_ready); end
        n_compared++; if (frames_issued !== 16'd2) begin n_failed++; $display("[TB] FAIL b2b_count2: got %0d required 2", frames_issued); end
        @(negedge clk);
        n_compared++; if (start !== 1'b0) begin n_failed++; $display("[TB] FAIL b2b_drain_start: got %b required 0", start); end
        @(negedge clk);
        for (int k = 0; k < 8; k++) exp_samples[k] = 32'hA000_0000 | (k + 8);
        n_compared++; if (start !== 1'b1) begin n_failed++; $display("[TB] FAIL b2b_start2: got %b required 1", start); end
        n_compared++; if (frame !== pack_exp()) begin n_failed++; $display("[TB] FAIL b2b_frame2: got %h required %h", frame, pack_exp()); end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        n_compared++; if (frames_issued !== 16'd3) begin n_failed++; $display("[TB] FAIL b2b_count3: got %0d required 3", frames_issued); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) send_sample(32'hDEAD_0000 | k);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        n_compared++; if (in_ready !== 1'b1) begin n_failed++; $display("[TB] FAIL flush_in_ready: got %b required 1", in_ready); end
        for (int k = 0; k < 8; k++) begin
            exp_samples[k] = 32'h1111_0000 * (k + 1);
            send_sample(exp_samples[k]);
            if (k == 6) begin
                n_compared++; if (start !== 1'b0) begin n_failed++; $display("[TB] FAIL flush_start_early: got %b required 0", start); end
            end
        end
        @(negedge clk);
        n_compared++; if (start !== 1'b1) begin n_failed++; $display("[TB] FAIL flush_start: got %b required 1", start); end
        n_compared++; if (frame !== pack_exp()) begin n_failed++; $display("[TB] FAIL flush_frame: got %h required %h", frame, pack_exp()); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) send_sample(32'h5555_0000 | k);
        #2;
        reset = 1'b1;
        #1;
        n_compared++; if (start !== 1'b0) begin n_failed++; $display("[TB] FAIL midreset_start: got %b required 0", start); end
        n_compared++; if (frame !== 256'h0) begin n_failed++; $display("[TB] FAIL midreset_frame: got %h required 0", frame); end
        n_compared++; if (frames_issued !== 16'd0) begin n_failed++; $display("[TB] FAIL midreset_count: got %0d required 0", frames_issued); end
        n_compared++; if (overflow_seen !== 1'b0) begin n_failed++; $display("[TB] FAIL midreset_overflow: got %b required 0", overflow_seen); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_samples[k] = 32'hC000_0000 | (k * 3);
            send_sample(exp_samples[k]);
        end
        @(negedge clk);
        n_compared++; if (start !== 1'b1) begin n_failed++; $display("[TB] FAIL midreset_start2: got %b required 1", start); end
        n_compared++; if (frame !== pack_exp()) begin n_failed++; $display("[TB] FAIL midreset_frame2: got %h required %h", frame, pack_exp()); end
    endtask

`ifdef FFT_FRAMER_BITREV_EN
    task automatic test_bitrev();
        logic [255:0] exp_frame;
        exp_frame = 256'h00000000_00040000_00020000_00060000_00010000_00050000_00030000_00070000;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) send_sample(32'(k) << 16);
        @(negedge clk);
        n_compared++; if (start !== 1'b1) begin n_failed++; $display("[TB] FAIL bitrev_start: got %b required 1", start); end
        n_compared++; if (frame !== exp_frame) begin n_failed++; $display("[TB] FAIL bitrev_frame: got %h required %h", frame, exp_frame); end
    endtask
`endif

    initial begin
        n_compared = 0;
        n_failed   = 0;
        reset      = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        done       = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_single_frame();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef FFT_FRAMER_BITREV_EN
        test_bitrev();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fft_sample_framer.md
Name: fft_sample_framer

Overview:
- Upstream feeder for the 8-point floating-point FFT core (`fft_fp`).
- Accepts a serial valid/ready stream of complex samples, one per beat. Each sample is 32 bits: fp16 real in [31:16], fp16 imaginary in [15:0].
- Packs every N samples into one N*WIDTH-bit frame and drives the core's `inputs`/`start`. It releases the frame once the core raises `done`.
- Ping-pong buffered: the next frame fills while the current one is being transformed.

Parameters:
- N, 8, points per frame; power of two, ≥2.
- WIDTH, 32, bits per complex sample.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  sample, fp16 re[WIDTH-1:WIDTH/2], fp16 im[WIDTH/2-1:0]; not interpreted.
- in_valid  in  1  sample present.
- in_ready  out  1  framer can accept a sample.
- flush  in  1  synchronous; discards the partially filled bank.
- frame  out  N*WIDTH  packed frame to the FFT `inputs`.
- start  out  1  to the FFT `start`.
- done  in  1  from the FFT `done`.
- frames_issued  out  16  count of frames released by a `done` handshake; wraps.
- overflow_seen  out  1  sticky: `in_valid` was high while `in_ready` was low.

Behaviour:
- Reset values (async):
  - `start`=0, `frame`=0, `frames_issued`=0, `overflow_seen`=0.
  - Both banks EMPTY; wr_bank=0, rd_bank=0, wr_idx=0, FSM=IDLE.
- Storage: two banks of N×WIDTH registers. Each bank state is EMPTY, FILLING or FULL.
- Write side:
  - `in_ready` = (state[wr_bank] != FULL); combinational from registered state.
  - Accept occurs when `in_valid` && `in_ready` at a rising edge. The sample goes to slot wr_idx; wr_idx increments; bank state becomes FILLING.
  - Accept with wr_idx==N-1: bank becomes FULL, wr_idx→0, wr_bank toggles.
  - If the toggled-to bank is still FULL, `in_ready` drops the next cycle and stays low until that bank is released.
- Packing: slot k occupies frame bits [(N-k)*WIDTH-1 : (N-k-1)*WIDTH]. Sample 0 is in the MSBs.
  - Example: stream 1,2,3,4,4,3,2,1 (im=0) → frame 0x3c000000_40000000_42000000_44000000_44000000_42000000_40000000_3c000000.
- Issue FSM:
  - IDLE: if state[rd_bank]==FULL → register `frame`=bank[rd_bank], `start`←1, go RUN.
  - RUN: hold `frame` and `start`. On `done`=1 → `start`←0, state[rd_bank]←EMPTY, rd_bank toggles, `frames_issued`+1, go DRAIN.
  - DRAIN: wait for `done`=0, then go IDLE. This guarantees a stale `done` never releases the next frame.
  - `frame` holds its last value in DRAIN and IDLE; it changes only on IDLE→RUN.
- Latency:
  - `start` rises one cycle after the edge that accepts sample N-1, provided the FSM is IDLE.
  - The minimum gap between `start` pulses is RUN length + 2 cycles.
- Simultaneous events:
  - A bank release and an accept into the other bank in the same edge are both honoured.
  - A release of bank X makes `in_ready` high the next cycle when wr_bank==X.
- `flush`:
  - Affects only wr_bank when it is FILLING: state→EMPTY, wr_idx→0.
  - FULL banks and the in-flight frame are untouched.
  - `flush` and an accept in the same cycle: `flush` wins and the sample is dropped.
- `overflow_seen` is sticky and clears only on reset. The rejected sample is not stored.
- Reset mid-operation: everything returns immediately to reset values. `start` falls asynchronously; the partial frame is lost.

Optional Feature:
- Macro: `FFT_FRAMER_BITREV_EN`.
- Defined: sample k is written to slot bitrev(k) over log2(N) bits, so the frame is presented in bit-reversed order for in-place DIT cores. N=8 mapping: 0,4,2,6,1,5,3,7. All handshakes, counts and latency are unchanged.
- Undefined: natural order as in Packing.

Test Plan:
- Reset, stream 1,2,3,4,4,3,2,1 (fp16, im 0), `done` tied to 0 → `start`=1 one cycle after the 8th accept; `frame` = the 256-bit value above; `frames_issued`=0.
- Raise `done` for 1 cycle → `start`=0 next cycle, `frames_issued`=1; `start` stays 0 until `done` is low and another full frame exists.
- Stream 24 samples back-to-back, `done`=0 → 16 accepted; `in_ready`=0 after the 16th; `overflow_seen`=1. Pulse `done` → `in_ready`=1 next cycle; second frame issued after DRAIN.
- Send 5 samples, assert `flush`, then send 8 samples 0x11110000..0x88880000 → first frame contains only those 8; the 5 flushed samples are absent.
- Assert `reset` while in RUN with 3 samples in the second bank → `start`, `frame`, counters at 0 immediately; next 8 samples form a fresh frame.
- With `FFT_FRAMER_BITREV_EN`: stream 0..7 as re=k → slots hold 0,4,2,6,1,5,3,7 MSB-first.
